// File: rtl/alu_share_arbiter_pkg.sv
// rtl/alu_share_arbiter_pkg.sv - ALUCtrl codes and legal-code check shared by ALU, arbiter and bench
package alu_share_arbiter_pkg;

    localparam int CTRL_W = 4;

    typedef enum logic [CTRL_W-1:0] {
        ALU_AND   = 4'h0,
        ALU_OR    = 4'h1,
        ALU_ADD   = 4'h2,
        ALU_SUB   = 4'h6,
        ALU_PASSB = 4'h7
    } alu_ctrl_e;

    function automatic logic alu_legal(input logic [CTRL_W-1:0] ctrl);
        case (ctrl)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_PASSB: alu_legal = 1'b1;
            default:                                     alu_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu64.sv
// rtl/alu64.sv - combinational DATA_W-bit ALU with Zero flag
module alu64
    import alu_share_arbiter_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0] bus_a,
    input  logic [DATA_W-1:0] bus_b,
    input  logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] bus_w,
    output logic              zero
);

    always_comb begin
        bus_w = '0;
        case (ctrl)
            ALU_AND:   bus_w = bus_a & bus_b;
            ALU_OR:    bus_w = bus_a | bus_b;
            ALU_ADD:   bus_w = bus_a + bus_b;
            ALU_SUB:   bus_w = bus_a - bus_b;
            ALU_PASSB: bus_w = bus_b;
            default:   bus_w = '0;
        endcase
    end

    assign zero = (bus_w == '0);

endmodule

// File: rtl/alu_rr_grant2.sv
// rtl/alu_rr_grant2.sv - two-way round-robin grant with priority register
module alu_rr_grant2 #(
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic valid0,
    input  logic valid1,
    output logic ready0,
    output logic ready1
);

    logic prio;

    // Grants are suppressed during reset so nothing is accepted into a clearing pipeline.
    assign ready0 = !rst && valid0 && (!valid1 || !prio);
    assign ready1 = !rst && valid1 && (!valid0 ||  prio);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio <= PRIO_INIT;
        end else if (ready0) begin
            prio <= 1'b1;
        end else if (ready1) begin
            prio <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - two requesters sharing one ALU through a two-stage pipeline
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              ReqValid0,
    input  logic [DATA_W-1:0] ReqA0,
    input  logic [DATA_W-1:0] ReqB0,
    input  logic [CTRL_W-1:0] ReqCtrl0,
    output logic              ReqReady0,
    output logic              RespValid0,
    output logic [DATA_W-1:0] Result0,
    output logic              Zero0,
    output logic              Err0,
    input  logic              ReqValid1,
    input  logic [DATA_W-1:0] ReqA1,
    input  logic [DATA_W-1:0] ReqB1,
    input  logic [CTRL_W-1:0] ReqCtrl1,
    output logic              ReqReady1,
    output logic              RespValid1,
    output logic [DATA_W-1:0] Result1,
    output logic              Zero1,
    output logic              Err1
);

    logic              accept;
    logic              s1_valid;
    logic              s1_tag;
    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] s1_b;
    logic [CTRL_W-1:0] s1_ctrl;
    logic [DATA_W-1:0] alu_w;
    logic              alu_zero;
    logic              legal;
    logic [DATA_W-1:0] res;
    logic              res_zero;

    alu_rr_grant2 #(.PRIO_INIT(PRIO_INIT)) u_grant (
        .clk    (CLK),
        .rst    (Reset),
        .valid0 (ReqValid0),
        .valid1 (ReqValid1),
        .ready0 (ReqReady0),
        .ready1 (ReqReady1)
    );

    assign accept = ReqReady0 | ReqReady1;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            s1_valid <= 1'b0;
            s1_tag   <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_ctrl  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_tag  <= ReqReady1;
                s1_a    <= ReqReady1 ? ReqA1    : ReqA0;
                s1_b    <= ReqReady1 ? ReqB1    : ReqB0;
                s1_ctrl <= ReqReady1 ? ReqCtrl1 : ReqCtrl0;
            end
        end
    end

    alu64 #(.DATA_W(DATA_W)) u_alu (
        .bus_a (s1_a),
        .bus_b (s1_b),
        .ctrl  (s1_ctrl),
        .bus_w (alu_w),
        .zero  (alu_zero)
    );

    // Illegal codes still occupy the slot but return a forced zero result with Err set.
    assign legal    = alu_legal(s1_ctrl);
    assign res      = legal ? alu_w : '0;
    assign res_zero = legal & alu_zero;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            RespValid0 <= 1'b0;
            Result0    <= '0;
            Zero0      <= 1'b0;
            Err0       <= 1'b0;
            RespValid1 <= 1'b0;
            Result1    <= '0;
            Zero1      <= 1'b0;
            Err1       <= 1'b0;
        end else begin
            RespValid0 <= s1_valid & !s1_tag;
            RespValid1 <= s1_valid &  s1_tag;
            if (s1_valid && !s1_tag) begin
                Result0 <= res;
                Zero0   <= res_zero;
                Err0    <= !legal;
            end
            if (s1_valid && s1_tag) begin
                Result1 <= res;
                Zero1   <= res_zero;
                Err1    <= !legal;
            end
        end
    end

endmodule
